// File: rtl/nebula_pkg.sv
// nebula: shared core types.
//   word_t          32-bit machine word (addresses and instructions)
//   ILEN            instruction length in bits
//   RESET_PC_DEFAULT default first fetch address after reset
//   fetch_entry_t   {pc, instr} pair handed from fetch to decode
//   align_pc()      clears the byte-offset bits of a fetch address
package nebula;
  localparam int ILEN = 32;

  typedef logic [ILEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t align_pc(input word_t pc);
    return {pc[ILEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory request/response channel, the
// redirect input and the decode-side instruction channel of the fetch stage.
//   master: the fetch stage (drives requests and the instruction stream)
//   slave : the environment (memory, redirect source and decode)
interface fetch_if;
  import nebula::*;

  logic  imem_req_valid_o;
  logic  imem_req_ready_i;
  word_t imem_req_addr_o;
  logic  imem_rsp_valid_i;
  word_t imem_rsp_data_i;
  logic  redirect_valid_i;
  word_t redirect_pc_i;
  logic  instr_valid_o;
  logic  instr_ready_i;
  word_t pc_o;
  word_t instr_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, instr_valid_o, pc_o, instr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_valid_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, instr_valid_o, pc_o, instr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_valid_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of DEPTH entries of type T.
//   clk_i, rst_n_i  clock, asynchronous active-low reset (pointers/count only)
//   flush           empties the FIFO; wins over a same-cycle push/pop
//   push, push_data write an entry (caller guarantees space)
//   pop             drop the head entry (caller guarantees non-empty)
//   head            current head entry (undefined while empty)
//   count           number of stored entries
module sync_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop)  rd_ptr <= inc_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is data only; it needs no reset because count gates its use.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push && !pop && !flush && count == CNT_W'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(pop && !flush && count == '0));
endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage feeding decode.
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   bus (master)    imem request/response channel, redirect input and the
//                   {pc, instr} valid/ready channel to decode
// Requests are issued from pc_q only while a buffer slot is reserved for the
// answer, so responses need no back-pressure. Addresses of outstanding
// requests sit in a tracking queue and are paired with the in-order
// responses. A redirect flushes the buffer and marks every outstanding
// response as stale so it is discarded on arrival.
module fetch
  import nebula::*;
#(
  parameter word_t RESET_PC        = RESET_PC_DEFAULT,
  parameter int    FIFO_DEPTH      = 2,
  parameter int    MAX_OUTSTANDING = 2
) (
  input logic     clk_i,
  input logic     rst_n_i,
  fetch_if.master bus
);
  localparam int BUF_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TRK_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W     = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;

  word_t                pc_q;
  logic [TRK_CNT_W-1:0] drop_q;
  logic [TRK_CNT_W-1:0] inflight;
  logic [BUF_CNT_W-1:0] buf_count;
  logic [TRK_CNT_W-1:0] inflight_next;
  logic [TRK_CNT_W-1:0] drop_next;
  logic [SUM_W-1:0]     credit_used;
  word_t                trk_head;
  fetch_entry_t         buf_head;
  fetch_entry_t         buf_in;
  logic                 req_valid;
  logic                 req_fire;
  logic                 rsp;
  logic                 drop_rsp;
  logic                 buf_pop;
  logic                 out_valid;

  // Each outstanding request holds a buffer slot until its response lands.
  assign credit_used = SUM_W'(inflight) + SUM_W'(buf_count);
  assign req_valid   = rst_n_i && !bus.redirect_valid_i
                     && (credit_used < SUM_W'(FIFO_DEPTH))
                     && (inflight < TRK_CNT_W'(MAX_OUTSTANDING));
  assign req_fire    = req_valid && bus.imem_req_ready_i;

  assign rsp         = bus.imem_rsp_valid_i;
  assign drop_rsp    = rsp && (drop_q != '0);
  assign drop_next   = drop_q - TRK_CNT_W'(drop_rsp);
  assign inflight_next = inflight + TRK_CNT_W'(req_fire) - TRK_CNT_W'(rsp);

  assign out_valid   = (buf_count != '0);
  assign buf_pop     = out_valid && bus.instr_ready_i;
  assign buf_in      = '{pc: trk_head, instr: bus.imem_rsp_data_i};

  sync_fifo #(.T(word_t), .DEPTH(MAX_OUTSTANDING)) u_track (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp),
    .head      (trk_head),
    .count     (inflight)
  );

  // A response arriving in a redirect cycle is stale; the flush discards it.
  sync_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush     (bus.redirect_valid_i),
    .push      (rsp && !drop_rsp),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // On redirect every response still outstanding after this cycle is stale:
  // the ones already marked (drop_next) plus the live ones
  // (inflight_next - drop_next), i.e. exactly inflight_next. Counting the
  // marked ones twice would swallow responses of the new stream.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else if (bus.redirect_valid_i) begin
      pc_q   <= align_pc(bus.redirect_pc_i);
      drop_q <= inflight_next;
    end else begin
      if (req_fire) pc_q <= pc_q + 32'd4;
      drop_q <= drop_next;
    end
  end

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = pc_q;
  assign bus.instr_valid_o    = out_valid;
  // Outputs read zero while the buffer is empty (including during reset).
  assign bus.pc_o             = out_valid ? buf_head.pc    : '0;
  assign bus.instr_o          = out_valid ? buf_head.instr : '0;

  a_rsp_has_request : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(rsp && inflight == '0));
endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
  import nebula::*;

  localparam word_t RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus_if();

  fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  typedef struct {
    word_t addr;
    int    due;
  } pend_t;

  int cmp = 0;
  int err = 0;

  // stimulus configuration (changed by the main sequence after a posedge)
  int    rdy_pct = 100;
  int    dec_pct = 100;
  int    max_lat = 1;
  int    redir_pct = 0;
  bit    redir_req = 0;
  word_t redir_target = '0;
  bit    collide_req = 0;
  int    collide_hits = 0;

  // bookkeeping shared between processes
  int           cyc = 0;
  pend_t        pend[$];
  fetch_entry_t sb[$];
  word_t        exp_req = RST_PC;
  word_t        gen_pc = RST_PC;
  word_t        last_acc = '0;
  int           acc_cnt = 0;
  bit           wrap_seen = 0;
  bit           fa_pending = 0;
  word_t        first_after = '0;
  int           hs_cnt = 0;
  bit           redir_now = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic word_t imem(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected decode stream: consecutive words from the last fetch target.
  task automatic topup();
    while (sb.size() < 16) begin
      sb.push_back('{pc: gen_pc, instr: imem(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // Driver: memory model, decode ready, redirects; records expectations.
  initial begin
    logic  rv;
    word_t rd;
    logic  rdy;
    logic  drdy;
    logic  rdir;
    word_t tgt;
    bus_if.imem_req_ready_i = 1'b0;
    bus_if.imem_rsp_valid_i = 1'b0;
    bus_if.imem_rsp_data_i  = '0;
    bus_if.redirect_valid_i = 1'b0;
    bus_if.redirect_pc_i    = '0;
    bus_if.instr_ready_i    = 1'b0;
    topup();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) continue;
      rv = 1'b0;
      rd = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rv = 1'b1;
        rd = imem(pend[0].addr);
        pend.delete(0);
      end
      rdy  = (int'($urandom_range(99)) < rdy_pct);
      drdy = (int'($urandom_range(99)) < dec_pct);
      rdir = 1'b0;
      tgt  = '0;
      if (redir_req) begin
        rdir = 1'b1; tgt = redir_target; redir_req = 0;
      end else if (collide_req && bus_if.instr_valid_o && rv && drdy) begin
        rdir = 1'b1; tgt = $urandom; collide_req = 0; collide_hits++;
      end else if (redir_pct > 0 && int'($urandom_range(99)) < redir_pct) begin
        rdir = 1'b1; tgt = $urandom;
      end
      bus_if.imem_rsp_valid_i = rv;
      bus_if.imem_rsp_data_i  = rd;
      bus_if.imem_req_ready_i = rdy;
      bus_if.instr_ready_i    = drdy;
      bus_if.redirect_valid_i = rdir;
      bus_if.redirect_pc_i    = tgt;
      redir_now = rdir;
      #4;
      if (bus_if.imem_req_valid_o && rdy) begin
        check("req_addr", bus_if.imem_req_addr_o, exp_req);
        pend.push_back('{addr: bus_if.imem_req_addr_o,
                         due: cyc + int'($urandom_range(max_lat, 1))});
        if (acc_cnt > 0 && last_acc == 32'hFFFF_FFFC && bus_if.imem_req_addr_o == 32'h0)
          wrap_seen = 1;
        if (fa_pending) begin
          first_after = bus_if.imem_req_addr_o;
          fa_pending = 0;
        end
        last_acc = bus_if.imem_req_addr_o;
        acc_cnt++;
        exp_req = exp_req + 32'd4;
      end
      if (rdir) begin
        check("req_valid_on_redirect", {31'b0, bus_if.imem_req_valid_o}, 32'h0);
        exp_req = {tgt[31:2], 2'b00};
        gen_pc = exp_req;
        sb.delete();
        fa_pending = 1;
      end
      topup();
    end
  end

  // Monitor: compares every decode handshake against the scoreboard.
  initial begin
    bit           hold;
    word_t        hpc;
    word_t        hins;
    fetch_entry_t e;
    hold = 0;
    hpc = '0;
    hins = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (hold) begin
          check("hold_valid", {31'b0, bus_if.instr_valid_o}, 32'h1);
          check("hold_pc", bus_if.pc_o, hpc);
          check("hold_instr", bus_if.instr_o, hins);
        end
        if (bus_if.instr_valid_o && bus_if.instr_ready_i) begin
          if (sb.size() == 0) begin
            cmp++;
            err++;
            $display("FAIL sb_empty: got pc 0x%08h expected none", bus_if.pc_o);
          end else begin
            e = sb.pop_front();
            check("pc", bus_if.pc_o, e.pc);
            check("instr", bus_if.instr_o, e.instr);
            hs_cnt++;
          end
        end
        hold = bus_if.instr_valid_o && !bus_if.instr_ready_i && !redir_now;
        hpc  = bus_if.pc_o;
        hins = bus_if.instr_o;
      end
    end
  end

  // Main sequence
  initial begin
    int  h;
    bit  found;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", {31'b0, bus_if.imem_req_valid_o}, 32'h0);
    check("rst_instr_valid", {31'b0, bus_if.instr_valid_o}, 32'h0);
    check("rst_pc", bus_if.pc_o, 32'h0);
    check("rst_instr", bus_if.instr_o, 32'h0);
    check("rst_req_addr", bus_if.imem_req_addr_o, RST_PC);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // streaming from reset
    repeat (20) @(negedge clk);
    check("stream_started", {31'b0, hs_cnt > 0}, 32'h1);

    // decode stall
    @(posedge clk); #1 dec_pct = 0;
    repeat (10) @(negedge clk);
    #2;
    check("stall_req_valid", {31'b0, bus_if.imem_req_valid_o}, 32'h0);
    check("stall_instr_valid", {31'b0, bus_if.instr_valid_o}, 32'h1);
    @(posedge clk); #1 dec_pct = 100;
    repeat (10) @(negedge clk);

    // redirect to 0x100 with two requests outstanding
    @(posedge clk); #1 max_lat = 3;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (pend.size() == 2) found = 1;
    end
    check("two_inflight_reached", {31'b0, found}, 32'h1);
    redir_target = 32'h0000_0100;
    redir_req = 1;
    repeat (20) @(negedge clk);
    @(posedge clk); #1 max_lat = 1;

    // unaligned redirect target
    redir_target = 32'h0000_0203;
    redir_req = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (!redir_req && !fa_pending) found = 1;
    end
    check("aligned_fetch_seen", {31'b0, found}, 32'h1);
    check("aligned_fetch_addr", first_after, 32'h0000_0200);
    repeat (10) @(negedge clk);

    // redirect colliding with a decode handshake and a memory response
    @(posedge clk); #1 collide_req = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (collide_hits > 0) found = 1;
    end
    check("collision_redirect_hit", {31'b0, found}, 32'h1);
    repeat (20) @(negedge clk);

    // address wrap
    @(posedge clk); #1;
    redir_target = 32'hFFFF_FFF8;
    redir_req = 1;
    repeat (20) @(negedge clk);
    check("pc_wrap_seen", {31'b0, wrap_seen}, 32'h1);

    // random traffic with redirects
    @(posedge clk); #1;
    rdy_pct = 70; dec_pct = 70; max_lat = 4; redir_pct = 5;
    repeat (10000) @(negedge clk);

    // drain under ideal conditions
    @(posedge clk); #1;
    rdy_pct = 100; dec_pct = 100; max_lat = 1; redir_pct = 0;
    h = hs_cnt;
    repeat (60) @(negedge clk);
    check("drain_progress", {31'b0, hs_cnt > h + 20}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
